traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

- Intersection phase controller for a two-way (NS/EW) crossing.
- Sequences vehicle and pedestrian lights through a fixed phase ring.
- Drives the downstream phase timer through a start pulse plus load value, and advances on the timer's done flag.
- Sits directly upstream of the phase timer. Consumes only `timer_done`, and owns every `timer_start` and `timer_load` decision.

## Interface
- `GREEN_TICKS`, default 30: green duration in timer ticks, range 1–255.
- `YELLOW_TICKS`, default 5: yellow duration, range 1–255.
- `ALLRED_TICKS`, default 2: all-red clearance duration, range 1–255.
- `PED_TICKS`, default 10: pedestrian walk duration, range 1–255.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous assertion, active-low.
- `ped_req` input 1: asynchronous push-button level. Only present with `PED_REQ_EN`.
- `timer_done` input 1: phase timer expired. Level signal; stays high while the timer is idle.
- `timer_start` output 1: one-cycle start pulse to the timer. Registered.
- `timer_load` output 8: tick count for the phase being started. Registered; valid whenever `timer_start`=1.
- `ns_light` output 3: NS lights, one-hot {red, yellow, green}.
- `ew_light` output 3: EW lights, one-hot {red, yellow, green}.
- `ped_walk` output 1: walk signal, high only in PED_WALK.

## Operation
- States: INIT, NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, PED_WALK.
- Phase ring: INIT→NS_GREEN→NS_YELLOW→ALLRED_A→EW_GREEN→EW_YELLOW→ALLRED_B→NS_GREEN.
- From ALLRED_A or ALLRED_B:
  - If `ped_pending`=1, go to PED_WALK.
  - PED_WALK then exits to the green the all-red was heading for (EW_GREEN after ALLRED_A, NS_GREEN after ALLRED_B). A return-target register holds this.
- Light decode is purely from the state register:
  - Green/yellow states: the named direction shows green/yellow; the other direction is red.
  - INIT, ALLRED_x, PED_WALK: both directions red.
- Phase entry:
  - In the first cycle of every state, `timer_start`=1 and `timer_load`=that state's TICKS.
  - INIT uses ALLRED_TICKS.
- Arming:
  - `armed` clears on entry and sets at the end of the entry cycle.
  - The state advances on the first cycle with `armed`=1 and `timer_done`=1.
  - `timer_done` is ignored in the entry cycle, because the timer still shows the stale done from the previous phase.
- Timer contract:
  - The timer loads on the rising edge of its start input.
  - It holds done low until the count has fully drained.
  - Consecutive start pulses are always separated by at least 2 low cycles.
- Pedestrian path (`PED_REQ_EN` only):
  - `ped_req` passes through a 2-flop synchronizer, then rising-edge detection.
  - An edge sets the sticky `ped_pending` flag.
  - `ped_pending` clears on PED_WALK entry.
  - If a set and the clear land in the same cycle, set wins; that request is serviced at the next all-red.
  - Holding the button produces one request only.

## Timing
- Reset values: state=INIT, `timer_start`=0, `timer_load`=0, `ns_light`=`ew_light`=3'b100, `ped_walk`=0, `armed`=0, `ped_pending`=0, synchronizer flops 0.
- The first rising edge after `rst_n` deasserts asserts `timer_start` with load ALLRED_TICKS, via the INIT entry flag.
- Phase length is TICKS+3 cycles from the entry cycle through the cycle in which `timer_done` is sampled. The next state is visible the following cycle.
- `ped_req` edge to `ped_pending`=1: 3 cycles.
- Reset asserted mid-phase: all outputs return to reset values immediately (asynchronously). The timer shares `rst_n`.
- Never two greens at once. Every green↔green transition passes through yellow plus an all-red.

## Configuration
- `TRAFFIC_PED_REQ_EN` defined:
  - `ped_req` port, synchronizer, `ped_pending` and the PED_WALK state exist.
- `TRAFFIC_PED_REQ_EN` undefined:
  - None of the above exist.
  - `ped_walk` is tied to 0.
  - ALLRED_x always proceeds straight to the next green.

## Structure
- Package `traffic_pkg` holds:
  - `state_e` enum.
  - Light encodings `LIGHT_RED`=3'b100, `LIGHT_YEL`=3'b010, `LIGHT_GRN`=3'b001.
  - Default tick constants.
- One sub-module, `ped_req_sync`: 2-flop synchronizer plus rising-edge pulse, reset to 0 by `rst_n`.
- The controller is wired to the phase timer in the intersection top level.

## Test plan
Bench uses the controller plus the real phase timer, GREEN=4, YELLOW=2, ALLRED=1, PED=3.
- Reset release:
  - `timer_start` pulses in cycle 1 with `timer_load`=1.
  - INIT lasts 4 cycles, then NS green for 7 cycles, NS yellow for 5, ALLRED_A for 4.
- Full ring, no pedestrian: the state sequence and per-phase cycle counts match the formula for 3 full cycles, with never both greens active.
- Button pressed for 1 cycle during NS_GREEN:
  - After ALLRED_A, `ped_walk`=1 for 6 cycles with both directions red, then EW_GREEN.
  - `ped_pending` clears.
- Button held for 40 cycles: exactly one PED_WALK.
- Request arriving in the PED_WALK entry cycle: a second PED_WALK follows at ALLRED_B.
- Reset asserted in the middle of EW_YELLOW: lights are immediately red/red, `timer_start`=0, and the sequence restarts from INIT.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase controller: state encoding, light codes, default tick counts.
// PED_WALK exists only when TRAFFIC_PED_REQ_EN is defined.
package traffic_pkg;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_A  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALLRED_B  = 3'd6
`ifdef TRAFFIC_PED_REQ_EN
    , PED_WALK = 3'd7
`endif
  } state_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam int unsigned GREEN_TICKS_DEF  = 30;
  localparam int unsigned YELLOW_TICKS_DEF = 5;
  localparam int unsigned ALLRED_TICKS_DEF = 2;
  localparam int unsigned PED_TICKS_DEF    = 10;

  // {ns, ew} light pair for a state; anything not a named green/yellow shows red both ways.
  function automatic logic [5:0] light_decode(state_e s);
    case (s)
      NS_GREEN:  light_decode = {LIGHT_GRN, LIGHT_RED};
      NS_YELLOW: light_decode = {LIGHT_YEL, LIGHT_RED};
      EW_GREEN:  light_decode = {LIGHT_RED, LIGHT_GRN};
      EW_YELLOW: light_decode = {LIGHT_RED, LIGHT_YEL};
      default:   light_decode = {LIGHT_RED, LIGHT_RED};
    endcase
  endfunction

endpackage

// File: rtl/ped_req_sync.sv
// Push-button synchronizer: 2 flops then rising-edge pulse, so a request shows up 2 cycles after the pin.
// Exists only when TRAFFIC_PED_REQ_EN is defined; a held button yields a single pulse.
`ifdef TRAFFIC_PED_REQ_EN
module ped_req_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= req_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule
`endif

// File: rtl/traffic_light_ctrl.sv
// Phase-ring controller: each phase lasts TICKS+3 cycles, start pulse and lights registered off the state.
// TRAFFIC_PED_REQ_EN adds the ped_req input, sticky request flag and PED_WALK phase.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = GREEN_TICKS_DEF,
  parameter int unsigned YELLOW_TICKS = YELLOW_TICKS_DEF,
  parameter int unsigned ALLRED_TICKS = ALLRED_TICKS_DEF,
  parameter int unsigned PED_TICKS    = PED_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic       ped_req,
`endif
  input  logic       timer_done,
  output logic       timer_start,
  output logic [7:0] timer_load,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk
);

  if (GREEN_TICKS == 0 || GREEN_TICKS > 255 || YELLOW_TICKS == 0 || YELLOW_TICKS > 255 ||
      ALLRED_TICKS == 0 || ALLRED_TICKS > 255 || PED_TICKS == 0 || PED_TICKS > 255) begin : g_bad_ticks
    $error("traffic_light_ctrl: tick parameters must lie in 1..255");
  end

  localparam logic [7:0] GRN_LD = 8'(GREEN_TICKS);
  localparam logic [7:0] YEL_LD = 8'(YELLOW_TICKS);
  localparam logic [7:0] ALR_LD = 8'(ALLRED_TICKS);

  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic       init_pend_q, init_pend_d;
  logic       timer_start_q, timer_start_d;
  logic [7:0] timer_load_q, timer_load_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;

`ifdef TRAFFIC_PED_REQ_EN
  localparam logic [7:0] PED_LD = 8'(PED_TICKS);

  logic   ped_pulse;
  logic   ped_pending_q, ped_pending_d;
  logic   ped_walk_q, ped_walk_d;
  state_e ret_q, ret_d;

  ped_req_sync u_ped_req_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (ped_req),
    .pulse_o (ped_pulse)
  );
`endif

  function automatic logic [7:0] phase_ticks(state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   phase_ticks = GRN_LD;
      NS_YELLOW, EW_YELLOW: phase_ticks = YEL_LD;
`ifdef TRAFFIC_PED_REQ_EN
      PED_WALK:             phase_ticks = PED_LD;
`endif
      default:              phase_ticks = ALR_LD;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    armed_d       = 1'b1;
    init_pend_d   = 1'b0;
    timer_start_d = 1'b0;
    timer_load_d  = timer_load_q;
`ifdef TRAFFIC_PED_REQ_EN
    ret_d         = ret_q;
`endif
    // INIT is entered by reset itself, so its start pulse comes from a flag rather than a transition.
    if (init_pend_q) begin
      armed_d       = 1'b0;
      timer_start_d = 1'b1;
      timer_load_d  = ALR_LD;
    end else if (armed_q && timer_done) begin
      case (state_q)
        INIT:      state_d = NS_GREEN;
        NS_GREEN:  state_d = NS_YELLOW;
        NS_YELLOW: state_d = ALLRED_A;
        ALLRED_A: begin
          state_d = EW_GREEN;
`ifdef TRAFFIC_PED_REQ_EN
          if (ped_pending_q) begin
            state_d = PED_WALK;
            ret_d   = EW_GREEN;
          end
`endif
        end
        EW_GREEN:  state_d = EW_YELLOW;
        EW_YELLOW: state_d = ALLRED_B;
        ALLRED_B: begin
          state_d = NS_GREEN;
`ifdef TRAFFIC_PED_REQ_EN
          if (ped_pending_q) begin
            state_d = PED_WALK;
            ret_d   = NS_GREEN;
          end
`endif
        end
`ifdef TRAFFIC_PED_REQ_EN
        PED_WALK:  state_d = ret_q;
`endif
        default:   state_d = INIT;
      endcase
      armed_d       = 1'b0;
      timer_start_d = 1'b1;
      timer_load_d  = phase_ticks(state_d);
    end
    {ns_light_d, ew_light_d} = light_decode(state_d);
`ifdef TRAFFIC_PED_REQ_EN
    ped_walk_d    = (state_d == PED_WALK);
    // A new press in the same cycle as the walk-entry clear survives for the next all-red.
    ped_pending_d = ped_pulse | (ped_pending_q & ~(ped_walk_d & (state_q != PED_WALK)));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      armed_q       <= 1'b0;
      init_pend_q   <= 1'b1;
      timer_start_q <= 1'b0;
      timer_load_q  <= 8'd0;
      ns_light_q    <= LIGHT_RED;
      ew_light_q    <= LIGHT_RED;
`ifdef TRAFFIC_PED_REQ_EN
      ped_pending_q <= 1'b0;
      ped_walk_q    <= 1'b0;
      ret_q         <= INIT;
`endif
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      init_pend_q   <= init_pend_d;
      timer_start_q <= timer_start_d;
      timer_load_q  <= timer_load_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
`ifdef TRAFFIC_PED_REQ_EN
      ped_pending_q <= ped_pending_d;
      ped_walk_q    <= ped_walk_d;
      ret_q         <= ret_d;
`endif
    end
  end

  assign timer_start = timer_start_q;
  assign timer_load  = timer_load_q;
  assign ns_light    = ns_light_q;
  assign ew_light    = ew_light_q;
`ifdef TRAFFIC_PED_REQ_EN
  assign ped_walk    = ped_walk_q;
`else
  assign ped_walk    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl driving a phase timer (GREEN=4, YELLOW=2, ALLRED=1, PED=3).
// Pedestrian sequences run only when TRAFFIC_PED_REQ_EN is defined.
module tb_traffic_light_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ped_req = 1'b0;
  logic       timer_done;
  logic       timer_start;
  logic [7:0] timer_load;
  logic [2:0] ns_light, ew_light;
  logic       ped_walk;

  logic [7:0] tmr_cnt;
  logic       tmr_prev;

  int   checks = 0;
  int   errors = 0;
  int   g_cyc = 0;
  int   ped_on = -1;
  int   ped_off = -1;
  logic dual_grn = 1'b0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .GREEN_TICKS  (4),
    .YELLOW_TICKS (2),
    .ALLRED_TICKS (1),
    .PED_TICKS    (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef TRAFFIC_PED_REQ_EN
    .ped_req     (ped_req),
`endif
    .timer_done  (timer_done),
    .timer_start (timer_start),
    .timer_load  (timer_load),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .ped_walk    (ped_walk)
  );

  // Phase timer: loads on a start rising edge, done stays low until the count has drained.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_cnt    <= 8'd0;
      tmr_prev   <= 1'b0;
      timer_done <= 1'b1;
    end else begin
      tmr_prev <= timer_start;
      if (timer_start && !tmr_prev) begin
        tmr_cnt    <= timer_load;
        timer_done <= 1'b0;
      end else if (tmr_cnt != 8'd0) begin
        tmr_cnt <= tmr_cnt - 8'd1;
      end else begin
        timer_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ped();
    ped_req = (g_cyc >= ped_on) && (g_cyc < ped_off);
  endtask

  // Called at the entry-cycle sample point; returns at the sample point of the next phase's entry.
  // pa/pl schedule a button press pl cycles long starting pa cycles after entry.
  task automatic ph(input string tag, input logic [2:0] ns, input logic [2:0] ew, input logic walk,
                    input int len, input int load, input int pa = 0, input int pl = 0);
    int n;
    int extra;
    if (pl > 0) begin
      ped_on  = g_cyc + pa;
      ped_off = ped_on + pl;
    end
    drive_ped();
    chk($sformatf("%s_start", tag), {31'd0, timer_start}, 32'd1);
    chk($sformatf("%s_load", tag), {24'd0, timer_load}, load);
    chk($sformatf("%s_lights", tag), {25'd0, ns_light, ew_light, ped_walk}, {25'd0, ns, ew, walk});
    n = 1;
    extra = 0;
    while (n < 300) begin
      @(negedge clk);
      g_cyc++;
      drive_ped();
      if (ns_light == G && ew_light == G) dual_grn = 1'b1;
      if ({ns_light, ew_light, ped_walk} != {ns, ew, walk}) break;
      if (timer_start) extra++;
      n++;
    end
    chk($sformatf("%s_len", tag), n, len);
    chk($sformatf("%s_restart", tag), extra, 0);
  endtask

  task automatic ring_plain(input string p);
    ph({p, "_nsg"}, G, R, 1'b0, 7, 4);
    ph({p, "_nsy"}, Y, R, 1'b0, 5, 2);
    ph({p, "_ara"}, R, R, 1'b0, 4, 1);
    ph({p, "_ewg"}, R, G, 1'b0, 7, 4);
    ph({p, "_ewy"}, R, Y, 1'b0, 5, 2);
    ph({p, "_arb"}, R, R, 1'b0, 4, 1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #10;
    chk("rst_start", {31'd0, timer_start}, 32'd0);
    chk("rst_load", {24'd0, timer_load}, 32'd0);
    chk("rst_ns", {29'd0, ns_light}, {29'd0, R});
    chk("rst_ew", {29'd0, ew_light}, {29'd0, R});
    chk("rst_walk", {31'd0, ped_walk}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("cyc0_start", {31'd0, timer_start}, 32'd0);
    @(negedge clk);
    g_cyc = 1;
    ph("init", R, R, 1'b0, 4, 1);
    ring_plain("r0");
    ring_plain("r1");
    ring_plain("r2");

`ifdef TRAFFIC_PED_REQ_EN
    // single-cycle press during NS green
    ph("p1_nsg", G, R, 1'b0, 7, 4, 2, 1);
    ph("p1_nsy", Y, R, 1'b0, 5, 2);
    ph("p1_ara", R, R, 1'b0, 4, 1);
    ph("p1_walk", R, R, 1'b1, 6, 3);
    ph("p1_ewg", R, G, 1'b0, 7, 4);
    ph("p1_ewy", R, Y, 1'b0, 5, 2);
    ph("p1_arb", R, R, 1'b0, 4, 1);
    // button held for 40 cycles
    ph("h_nsg", G, R, 1'b0, 7, 4, 1, 40);
    ph("h_nsy", Y, R, 1'b0, 5, 2);
    ph("h_ara", R, R, 1'b0, 4, 1);
    ph("h_walk", R, R, 1'b1, 6, 3);
    ph("h_ewg", R, G, 1'b0, 7, 4);
    ph("h_ewy", R, Y, 1'b0, 5, 2);
    ph("h_arb", R, R, 1'b0, 4, 1);
    ring_plain("h2");
    // second press lands on the same edge that clears the first
    ph("s_nsg", G, R, 1'b0, 7, 4, 2, 1);
    ph("s_nsy", Y, R, 1'b0, 5, 2);
    ph("s_ara", R, R, 1'b0, 4, 1, 1, 1);
    ph("s_walk", R, R, 1'b1, 6, 3);
    ph("s_ewg", R, G, 1'b0, 7, 4);
    ph("s_ewy", R, Y, 1'b0, 5, 2);
    ph("s_arb", R, R, 1'b0, 4, 1);
    ph("s_walk2", R, R, 1'b1, 6, 3);
`endif

    ph("t_nsg", G, R, 1'b0, 7, 4);
    ph("t_nsy", Y, R, 1'b0, 5, 2);
    ph("t_ara", R, R, 1'b0, 4, 1);
    ph("t_ewg", R, G, 1'b0, 7, 4);
    @(negedge clk);
    @(negedge clk);
    chk("mid_ewy", {26'd0, ns_light, ew_light}, {26'd0, R, Y});
    rst_n = 1'b0;
    #1;
    chk("arst_ns", {29'd0, ns_light}, {29'd0, R});
    chk("arst_ew", {29'd0, ew_light}, {29'd0, R});
    chk("arst_start", {31'd0, timer_start}, 32'd0);
    chk("arst_load", {24'd0, timer_load}, 32'd0);
    chk("arst_walk", {31'd0, ped_walk}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    g_cyc = 0;
    #1 chk("rel_start0", {31'd0, timer_start}, 32'd0);
    @(negedge clk);
    g_cyc = 1;
    ph("re_init", R, R, 1'b0, 4, 1);
    ph("re_nsg", G, R, 1'b0, 7, 4);
    ph("re_nsy", Y, R, 1'b0, 5, 2);

    chk("no_dual_green", {31'd0, dual_grn}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

endmodule
